// File: rtl/blink_pkg.sv
// Shared constants for the LED blink output path and the button conditioning
// input path: FSM state encodings and default phase lengths.
package blink_pkg;

    // Blink FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    // Default phase lengths in clock cycles
    localparam int unsigned DEF_ON_CYCLES  = 32'h8000;
    localparam int unsigned DEF_OFF_CYCLES = 32'h8000;

    // The debounce thresholds on the button side use the same time base
    localparam int unsigned DEB_PRESS_CYCLES   = DEF_ON_CYCLES;
    localparam int unsigned DEB_RELEASE_CYCLES = DEF_OFF_CYCLES;

endpackage

// File: rtl/blink_phase_timer.sv
// Loadable down-counter used to time one phase (LED on or LED off).
// expired is high while the counter holds zero; it never wraps below zero.
module blink_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    // Counter register: clear has priority over load, load over decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/led_blink_driver.sv
// Turns a single-cycle start request into N LED pulses, each ON_CYCLES high
// followed by OFF_CYCLES low. busy covers the whole pattern, done pulses for
// one cycle after normal completion, abort drops everything back to idle.
module led_blink_driver
    import blink_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int          NUM_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] blink_count,
    input  logic             abort,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    // Timer reload values: a phase of K cycles counts K-1 down to 0
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    logic [1:0]       state;
    logic [NUM_W-1:0] remaining;

    logic             timer_clear;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_value;
    logic             timer_dec;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expired;

    logic             start_ok;

    // A start is honoured only from idle, without abort, and with a nonzero count
    assign start_ok = start && !abort && (blink_count != '0);

    blink_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .load       (timer_load),
        .load_value (timer_load_value),
        .dec        (timer_dec),
        .value      (timer_value),
        .expired    (timer_expired)
    );

    // Timer control: reload on every phase entry, count down otherwise, clear on abort
    always_comb begin
        timer_clear      = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_dec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    timer_load       = 1'b1;
                    timer_load_value = ON_LOAD;
                end
            end
            ST_ON: begin
                if (abort) begin
                    timer_clear = 1'b1;
                end else if (timer_expired) begin
                    timer_load       = 1'b1;
                    timer_load_value = OFF_LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_OFF: begin
                if (abort) begin
                    timer_clear = 1'b1;
                end else if (timer_expired) begin
                    if (remaining != '0) begin
                        timer_load       = 1'b1;
                        timer_load_value = ON_LOAD;
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: begin
                timer_clear = 1'b1;
            end
        endcase
    end

    // Pattern FSM with registered LED, busy and done outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_ON;
                        remaining <= blink_count;
                        led_out   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        led_out   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (timer_expired) begin
                        state   <= ST_OFF;
                        led_out <= 1'b0;
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        remaining <= '0;
                        led_out   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (timer_expired) begin
                        if (remaining != '0) begin
                            state   <= ST_ON;
                            led_out <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    led_out   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver with ON_CYCLES=3, OFF_CYCLES=2.
// Every cycle the reference model predicts the {led_out, busy, done} triple
// for the next cycle and pushes it; the monitor pops and compares on negedge.
module tb_led_blink_driver;

    localparam int CNT_W = 16;
    localparam int NUM_W = 4;
    localparam int ON_C  = 3;
    localparam int OFF_C = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [NUM_W-1:0] blink_count;
    logic             abort;
    logic             led_out;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    logic [2:0] exp_q[$];   // {led_out, busy, done} per cycle
    logic [2:0] plan_q[$];  // remaining cycles of the pattern being played
    logic [2:0] cur_exp;

    led_blink_driver #(
        .CNT_W      (CNT_W),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .NUM_W      (NUM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .blink_count (blink_count),
        .abort       (abort),
        .led_out     (led_out),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    // ---------------- check helper ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle_no);
        end
    endtask

    // ---------------- reference model ----------------
    // A pattern of N blinks is N repetitions of ON_C cycles {1,1,0} and
    // OFF_C cycles {0,1,0}, followed by a single {0,0,1} completion cycle.
    // While busy, starts are ignored and abort empties the pattern.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            plan_q.delete();
            exp_q.delete();
            cur_exp = 3'b000;
        end else begin
            logic [2:0] nxt;
            if (cur_exp[1]) begin
                if (abort) begin
                    plan_q.delete();
                    nxt = 3'b000;
                end else begin
                    nxt = plan_q.pop_front();
                end
            end else if (start && !abort && blink_count != 0) begin
                for (int b = 0; b < int'(blink_count); b++) begin
                    for (int k = 0; k < ON_C; k++)  plan_q.push_back(3'b110);
                    for (int k = 0; k < OFF_C; k++) plan_q.push_back(3'b010);
                end
                plan_q.push_back(3'b001);
                nxt = plan_q.pop_front();
            end else begin
                nxt = 3'b000;
            end
            cur_exp = nxt;
            exp_q.push_back(nxt);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check("led_busy_done", int'({led_out, busy, done}), int'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int cnt);
        start       = 1'b1;
        blink_count = NUM_W'(cnt);
        tick(1);
        start       = 1'b0;
    endtask

    // Waits (bounded) until done is seen after an edge; leaves time in the done cycle
    task automatic wait_done(input int budget, output int at_cycle);
        int found;
        found    = 0;
        at_cycle = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done === 1'b1) begin
                found    = 1;
                at_cycle = cycle_no;
                break;
            end
        end
        check("done_seen_within_budget", found, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d1;
        int d2;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        blink_count = '0;
        tick(3);
        check("reset_led", int'(led_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        tick(2);

        // 1. Asynchronous reset in the middle of the ON phase
        pulse_start(2);
        tick(1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_led", int'(led_out), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        tick(2);
        reset = 1'b0;
        tick(20);

        // 2. Two blinks
        pulse_start(2);
        tick(14);

        // 3. Zero count ignored, then a single blink
        pulse_start(0);
        tick(10);
        pulse_start(1);
        tick(8);

        // 4. Start and a new count while busy are ignored
        pulse_start(3);
        tick(3);
        pulse_start(15);
        tick(16);

        // 5a. Abort in the middle of a run
        pulse_start(4);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_led", int'(led_out), 0);
        check("abort_busy", int'(busy), 0);
        tick(25);

        // 5b. Abort and start together in idle
        abort       = 1'b1;
        start       = 1'b1;
        blink_count = 4'd5;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        tick(10);

        // 6. Maximum count, then back-to-back start in the done cycle
        pulse_start(15);
        wait_done(100, d1);
        start       = 1'b1;
        blink_count = 4'd15;
        tick(1);
        start = 1'b0;
        check("b2b_led_next_cycle", int'(led_out), 1);
        wait_done(100, d2);
        check("b2b_done_spacing", d2 - d1, 15 * (ON_C + OFF_C) + 1);
        tick(5);

        // 7. Randomized traffic
        for (int i = 0; i < 800; i++) begin
            start       = ($urandom_range(0, 3) == 0);
            blink_count = NUM_W'($urandom_range(0, 15));
            abort       = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        start = 1'b0;
        abort = 1'b0;
        tick(100);

        check("scoreboard_backlog", exp_q.size(), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
